// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
// The arbiter connects through the slave modport; fetch/LS units and the RAM use master.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 8
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_data;
  logic                  if_done;
  logic                  if_busy;
  logic [1:0]            ls_rw_flag;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_write_data;
  logic [1:0]            ls_len;
  logic [DATA_WIDTH-1:0] ls_read_data;
  logic                  ls_done;
  logic                  ls_busy;
  logic [RAM_WIDTH-1:0]  mem_din;
  logic [RAM_WIDTH-1:0]  mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport master (
    output if_req, if_addr, ls_rw_flag, ls_addr, ls_write_data, ls_len, mem_din,
    input  if_data, if_done, if_busy, ls_read_data, ls_done, ls_busy,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, ls_rw_flag, ls_addr, ls_write_data, ls_len, mem_din,
    output if_data, if_done, if_busy, ls_read_data, ls_done, ls_busy,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (4B reads) and load/store
// (1/2/4B reads/writes), serialising each access into little-endian byte cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state;
  logic                  if_pend, ls_pend, serve_ls, wr_quiet;
  logic [2:0]            cnt, idx, idx_nx;
  logic                  last;
  logic [ADDR_WIDTH-1:0] if_addr_q, ls_addr_q, cur_addr, next_addr, mem_a_q;
  logic [DATA_WIDTH-1:0] ls_wdata_q, asm_q, asm_next, if_data_q, ls_rdata_q;
  logic [1:0]            ls_len_q;
  logic                  ls_wr_q;
  logic                  mem_wr_q;
  logic [RAM_WIDTH-1:0]  mem_dout_q;
  logic                  if_done_q, ls_done_q;
  logic                  if_busy_w, ls_busy_w, ls_req, if_cap, ls_cap;

  function automatic logic [RAM_WIDTH-1:0] byte_sel(input logic [DATA_WIDTH-1:0] w,
                                                    input logic [1:0] k);
    logic [DATA_WIDTH-1:0] sh;
    sh = w >> {k, 3'b000};
    return sh[RAM_WIDTH-1:0];
  endfunction

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  assign ls_req    = (bus.ls_rw_flag == 2'b01) || (bus.ls_rw_flag == 2'b10);
  assign if_busy_w = if_pend || ((state != IDLE) && !serve_ls);
  assign ls_busy_w = ls_pend || ((state != IDLE) && serve_ls);
  assign if_cap    = !clear && bus.if_req && !if_busy_w;
  assign ls_cap    = !clear && ls_req && !ls_busy_w;

  assign idx_nx    = idx + 3'd1;
  assign last      = (idx_nx == cnt);
  assign cur_addr  = serve_ls ? ls_addr_q : if_addr_q;
  assign next_addr = cur_addr + ADDR_WIDTH'(idx_nx);
  assign asm_next  = asm_q | (DATA_WIDTH'(bus.mem_din) << {idx[1:0], 3'b000});

  assign bus.if_data      = if_data_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_busy      = if_busy_w;
  assign bus.ls_read_data = ls_rdata_q;
  assign bus.ls_done      = ls_done_q;
  assign bus.ls_busy      = ls_busy_w;
  assign bus.mem_a        = mem_a_q;
  assign bus.mem_dout     = mem_dout_q;
  // The strobe is gated combinationally so a frozen block never repeats a write.
  assign bus.mem_wr       = mem_wr_q && rdy;

  // Control: arbitration, byte sequencing and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      if_pend    <= 1'b0;
      ls_pend    <= 1'b0;
      serve_ls   <= 1'b0;
      wr_quiet   <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state)
        IDLE: if (!clear) begin
          if (ls_pend) begin
            serve_ls <= 1'b1;
            ls_pend  <= 1'b0;
            cnt      <= len_to_n(ls_len_q);
            idx      <= '0;
            mem_a_q  <= ls_addr_q;
            wr_quiet <= 1'b0;
            if (ls_wr_q) begin
              state      <= WRITE;
              mem_wr_q   <= 1'b1;
              mem_dout_q <= byte_sel(ls_wdata_q, 2'd0);
            end else begin
              state <= READ;
            end
          end else if (if_pend) begin
            serve_ls <= 1'b0;
            if_pend  <= 1'b0;
            cnt      <= 3'd4;
            idx      <= '0;
            mem_a_q  <= if_addr_q;
            state    <= READ;
          end
        end
        READ: begin
          if (clear) begin
            state   <= IDLE;
            mem_a_q <= '0;
          end else if (last) begin
            state   <= IDLE;
            mem_a_q <= '0;
            if (serve_ls) begin
              ls_done_q  <= 1'b1;
              ls_rdata_q <= asm_next;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= asm_next;
            end
          end else begin
            idx     <= idx_nx;
            mem_a_q <= next_addr;
          end
        end
        WRITE: begin
          // A flush cannot retract bytes already on the bus, so the store finishes silently.
          if (clear) wr_quiet <= 1'b1;
          if (last) begin
            state      <= IDLE;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            mem_a_q    <= '0;
            ls_done_q  <= !(wr_quiet || clear);
          end else begin
            idx        <= idx_nx;
            mem_a_q    <= next_addr;
            mem_dout_q <= byte_sel(ls_wdata_q, idx_nx[1:0]);
          end
        end
        default: state <= IDLE;
      endcase
      if (if_cap) if_pend <= 1'b1;
      if (ls_cap) ls_pend <= 1'b1;
      if (clear) begin
        if_pend <= 1'b0;
        ls_pend <= 1'b0;
      end
    end
  end

  // Data: request latches and the byte assembly buffer
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (if_cap) if_addr_q <= bus.if_addr;
      if (ls_cap) begin
        ls_addr_q  <= bus.ls_addr;
        ls_wdata_q <= bus.ls_write_data;
        ls_len_q   <= bus.ls_len;
        ls_wr_q    <= bus.ls_rw_flag[1];
      end
      if (state == READ) asm_q <= asm_next;
      else               asm_q <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (combinational read, clocked write).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] ram [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_a = '0;
  logic [7:0] pre_d = '0;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_WIDTH(8)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_din = ram[bus.mem_a[9:0]];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    else if (pre_we) ram[pre_a] <= pre_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic if_issue(input logic [31:0] a);
    bus.if_req = 1'b1; bus.if_addr = a;
    tick();
    bus.if_req = 1'b0;
  endtask

  task automatic ls_issue(input logic [1:0] flag, input logic [1:0] len,
                          input logic [31:0] a, input logic [31:0] d);
    bus.ls_rw_flag = flag; bus.ls_len = len; bus.ls_addr = a; bus.ls_write_data = d;
    tick();
    bus.ls_rw_flag = 2'b00;
  endtask

  // Counts edges after the request edge until the chosen done pulse; -1 if it never comes.
  task automatic wait_done(input bit use_ls, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ((use_ls ? bus.ls_done : bus.if_done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ls_cnt, if_cnt, ls_at, if_at, wcnt;
    logic busy_ok;
    logic [31:0] a_k3;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_rw_flag = 2'b00; bus.ls_addr = '0; bus.ls_write_data = '0; bus.ls_len = 2'b00;

    poke(10'h100, 8'h11); poke(10'h101, 8'h22); poke(10'h102, 8'h33); poke(10'h103, 8'h44);
    for (int k = 0; k < 4; k++) begin
      poke(10'h200 + 10'(k), 8'h00);
      poke(10'h300 + 10'(k), 8'h00);
    end

    check("rst_if_done", 32'(bus.if_done), 32'h0);
    check("rst_ls_done", 32'(bus.ls_done), 32'h0);
    check("rst_busy", {30'b0, bus.if_busy, bus.ls_busy}, 32'h0);
    check("rst_mem_a", bus.mem_a, 32'h0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    check("rst_data", bus.if_data | bus.ls_read_data, 32'h0);
    rst = 1'b0;
    tick();

    // Fetch 4 bytes from 0x100
    if_issue(32'h100);
    check("if_busy_pend", 32'(bus.if_busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("if_mem_a", bus.mem_a, 32'h100 + 32'(k));
      check("if_no_done", 32'(bus.if_done), 32'h0);
    end
    tick();
    check("if_done_e4", 32'(bus.if_done), 32'h1);
    check("if_data", bus.if_data, 32'h44332211);
    tick();
    check("if_done_pulse", 32'(bus.if_done), 32'h0);
    check("if_busy_end", 32'(bus.if_busy), 32'h0);

    // Single byte load from 0x103
    ls_issue(2'b01, 2'b00, 32'h103, 32'h0);
    tick();
    check("lb_mem_a", bus.mem_a, 32'h103);
    tick();
    check("lb_done", 32'(bus.ls_done), 32'h1);
    check("lb_data", bus.ls_read_data, 32'h00000044);

    // Halfword store then word load
    tick();
    ls_issue(2'b10, 2'b01, 32'h200, 32'hDEADBEEF);
    tick();
    check("sh_b0", {bus.mem_a[15:0], 7'b0, bus.mem_wr, bus.mem_dout}, {16'h0200, 8'h01, 8'hEF});
    tick();
    check("sh_b1", {bus.mem_a[15:0], 7'b0, bus.mem_wr, bus.mem_dout}, {16'h0201, 8'h01, 8'hBE});
    tick();
    check("sh_done", {31'b0, bus.ls_done}, 32'h1);
    check("sh_idle_bus", {23'b0, bus.mem_wr, bus.mem_dout}, 32'h0);
    check("sh_rd_kept", bus.ls_read_data, 32'h00000044);
    ls_issue(2'b01, 2'b11, 32'h200, 32'h0);
    wait_done(1'b1, lat);
    check("lw_latency", 32'(lat), 32'd5);
    check("lw_data", bus.ls_read_data, 32'h0000BEEF);

    // Simultaneous IF and LS pulses: LS first, IF after one IDLE cycle
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    ls_issue(2'b01, 2'b00, 32'h100, 32'h0);
    bus.if_req = 1'b0;
    ls_cnt = 0; if_cnt = 0; ls_at = 0; if_at = 0; busy_ok = 1'b1; a_k3 = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.ls_done) begin ls_cnt++; ls_at = k; end
      if (bus.if_done) begin if_cnt++; if_at = k; end
      if (k <= 6 && !bus.if_busy) busy_ok = 1'b0;
      if (k == 3) a_k3 = bus.mem_a;
    end
    check("sim_ls_once", 32'(ls_cnt), 32'd1);
    check("sim_ls_at", 32'(ls_at), 32'd2);
    check("sim_if_once", 32'(if_cnt), 32'd1);
    check("sim_if_at", 32'(if_at), 32'd7);
    check("sim_if_busy", 32'(busy_ok), 32'h1);
    check("sim_if_start", a_k3, 32'h100);
    check("sim_ls_data", bus.ls_read_data, 32'h00000011);

    // rdy low for 3 cycles mid-fetch
    if_issue(32'h100);
    tick();
    tick();
    check("rdy_pre_a", bus.mem_a, 32'h101);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rdy_hold", {bus.mem_a[30:0], bus.mem_wr}, {31'h101, 1'b0});
    end
    rdy = 1'b1;
    lat = 5;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (bus.if_done === 1'b1) break;
    end
    check("rdy_latency", 32'(lat), 32'd8);
    check("rdy_data", bus.if_data, 32'h44332211);

    // Done pulse stretches while frozen
    ls_issue(2'b01, 2'b00, 32'h101, 32'h0);
    tick();
    tick();
    check("str_done", 32'(bus.ls_done), 32'h1);
    check("str_data", bus.ls_read_data, 32'h00000022);
    rdy = 1'b0;
    tick();
    check("str_held", 32'(bus.ls_done), 32'h1);
    rdy = 1'b1;
    tick();
    check("str_drop", 32'(bus.ls_done), 32'h0);

    // Flush during fetch byte 2, with an LS request in the same cycle
    if_issue(32'h100);
    tick(); tick(); tick();
    check("clr_at_b2", bus.mem_a, 32'h102);
    clear = 1'b1;
    bus.ls_rw_flag = 2'b01; bus.ls_addr = 32'h100; bus.ls_len = 2'b00;
    tick();
    clear = 1'b0;
    bus.ls_rw_flag = 2'b00;
    check("clr_if_idle", {bus.mem_a[30:0], bus.if_busy}, 32'h0);
    check("clr_ls_ignored", 32'(bus.ls_busy), 32'h0);
    if_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.if_done || bus.ls_done) if_cnt++;
    end
    check("clr_no_done", 32'(if_cnt), 32'd0);

    // Flush during a 4-byte store: all bytes land, done suppressed
    ls_issue(2'b10, 2'b11, 32'h300, 32'hCAFEF00D);
    tick();
    wcnt = bus.mem_wr ? 1 : 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ls_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_wr) wcnt++;
      if (bus.ls_done) ls_cnt++;
      tick();
    end
    check("clrw_bytes", 32'(wcnt), 32'd4);
    check("clrw_no_done", 32'(ls_cnt), 32'd0);
    check("clrw_ram", {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}, 32'hCAFEF00D);
    check("clrw_busy", 32'(bus.ls_busy), 32'h0);

    // Asynchronous reset mid-store
    ls_issue(2'b10, 2'b11, 32'h310, 32'h12345678);
    tick();
    tick();
    check("arst_pre_wr", 32'(bus.mem_wr), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_wr", 32'(bus.mem_wr), 32'h0);
    check("arst_a", bus.mem_a, 32'h0);
    check("arst_busy", {30'b0, bus.if_busy, bus.ls_busy}, 32'h0);
    #1 rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
